// File: rtl/alu_internal_seq_if.sv
//------------------------------------------------------------------------------
// alu_internal_seq_if : request/strobe bundle between ALU sequencer and decoder
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_internal_seq_if;
  logic       start;
  logic [2:0] op;
  logic       stall;
  logic       INTERNAL_MOV;
  logic       ADDRESS_MODE;
  logic       INTERNAL_INC_DEC;
  logic       INTERNAL_DEC;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, op, stall,
    input  INTERNAL_MOV, ADDRESS_MODE, INTERNAL_INC_DEC, INTERNAL_DEC,
    input  busy, done, err
  );

  modport slave (
    input  start, op, stall,
    output INTERNAL_MOV, ADDRESS_MODE, INTERNAL_INC_DEC, INTERNAL_DEC,
    output busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/alu_internal_seq.sv
//------------------------------------------------------------------------------
// alu_internal_seq : micro-step sequencer producing active-low Ctrl2 strobes
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_internal_seq #(
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_internal_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP1 = 2'd1,
    STEP2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_CYCLES - 1);

  // Strobe vectors ordered {MOV, ADDRESS_MODE, INC_DEC, DEC}, all active low
  localparam logic [3:0] STB_IDLE = 4'b1111;
  localparam logic [3:0] STB_A    = 4'b1011;
  localparam logic [3:0] STB_M    = 4'b0111;
  localparam logic [3:0] STB_I    = 4'b0101;
  localparam logic [3:0] STB_D    = 4'b0100;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       op_q, op_n;
  logic [3:0]       stb_q, stb_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             err_q, err_n;
  logic             accept;

  function automatic logic [3:0] step_strobes(input logic [2:0] code, input logic second);
    logic [3:0] s;
    case (code)
      3'd1:    s = STB_A;
      3'd2:    s = STB_M;
      3'd3:    s = STB_I;
      3'd4:    s = STB_D;
      3'd5:    s = second ? STB_I : STB_A;
      3'd6:    s = second ? STB_A : STB_D;
      default: s = STB_IDLE;
    endcase
    return s;
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    err_n   = 1'b0;
    accept  = 1'b0;

    case (state)
      IDLE: accept = bus.start;
      STEP1, STEP2: begin
        if (!bus.stall) begin
          if (cnt == LAST_CNT) begin
            cnt_n   = '0;
            state_n = (state == STEP1 && (op_q == 3'd5 || op_q == 3'd6)) ? STEP2 : DONE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        // A stalled DONE freezes the whole completion cycle, err included
        if (bus.stall) begin
          err_n = err_q;
        end else begin
          accept  = bus.start;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (accept) begin
      op_n  = bus.op;
      cnt_n = '0;
      if (bus.op == 3'd0 || bus.op == 3'd7) begin
        state_n = DONE;
        err_n   = (bus.op == 3'd7);
      end else begin
        state_n = STEP1;
      end
    end

    // Outputs are precomputed from the next state so they leave flops directly
    case (state_n)
      STEP1:   stb_n = step_strobes(op_n, 1'b0);
      STEP2:   stb_n = step_strobes(op_n, 1'b1);
      default: stb_n = STB_IDLE;
    endcase
    busy_n = (state_n == STEP1) || (state_n == STEP2);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= 3'd0;
      stb_q  <= STB_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      op_q   <= op_n;
      stb_q  <= stb_n;
      busy_q <= busy_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  assign bus.INTERNAL_MOV     = stb_q[3];
  assign bus.ADDRESS_MODE     = stb_q[2];
  assign bus.INTERNAL_INC_DEC = stb_q[1];
  assign bus.INTERNAL_DEC     = stb_q[0];
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.err              = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_internal_seq.sv
//------------------------------------------------------------------------------
// tb_alu_internal_seq : directed + random checks of two sequencer instances
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_internal_seq;

  localparam int SC0 = 2;
  localparam int SC1 = 1;

  // Expected word: {MOV, ADDR, INC_DEC, DEC, busy, done, err}
  localparam logic [6:0] IDLE_V = 7'b1111_000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic       stall;

  always #5 clk = ~clk;

  alu_internal_seq_if bus0 ();
  alu_internal_seq_if bus1 ();

  assign bus0.start = start;
  assign bus0.op    = op;
  assign bus0.stall = stall;
  assign bus1.start = start;
  assign bus1.op    = op;
  assign bus1.stall = stall;

  alu_internal_seq #(.STEP_CYCLES(SC0), .CNT_W(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  alu_internal_seq #(.STEP_CYCLES(SC1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0] q [2][$];
  logic [6:0] cur [2];

  function automatic logic [6:0] observe(input int i);
    if (i == 0)
      return {bus0.INTERNAL_MOV, bus0.ADDRESS_MODE, bus0.INTERNAL_INC_DEC,
              bus0.INTERNAL_DEC, bus0.busy, bus0.done, bus0.err};
    return {bus1.INTERNAL_MOV, bus1.ADDRESS_MODE, bus1.INTERNAL_INC_DEC,
            bus1.INTERNAL_DEC, bus1.busy, bus1.done, bus1.err};
  endfunction

  // Expand an accepted op into its full per-cycle output trace
  task automatic build_trace(input int i, input logic [2:0] code, input int sc);
    logic [3:0] steps [$];
    steps.delete();
    case (code)
      3'd1: steps.push_back(4'b1011);
      3'd2: steps.push_back(4'b0111);
      3'd3: steps.push_back(4'b0101);
      3'd4: steps.push_back(4'b0100);
      3'd5: begin steps.push_back(4'b1011); steps.push_back(4'b0101); end
      3'd6: begin steps.push_back(4'b0100); steps.push_back(4'b1011); end
      default: ;
    endcase
    foreach (steps[k])
      for (int c = 0; c < sc; c++)
        q[i].push_back({steps[k], 3'b100});
    q[i].push_back({4'b1111, 2'b01, code == 3'd7});
  endtask

  task automatic model_edge(input int i, input int sc);
    if (rst) begin
      q[i].delete();
      cur[i] = IDLE_V;
    end else if ((cur[i][2] || cur[i][1]) && stall) begin
      cur[i] = cur[i];
    end else if (q[i].size() > 0) begin
      cur[i] = q[i].pop_front();
    end else if (start) begin
      build_trace(i, op, sc);
      cur[i] = q[i].pop_front();
    end else begin
      cur[i] = IDLE_V;
    end
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_inv(input string tag, input logic [6:0] o);
    logic ok;
    ok = (o[4] | ~o[6]) & (o[3] | ~o[4]) & ~(~o[5] & ~o[6]);
    vectors++;
    assert (ok === 1'b1) else begin
      miscompares++;
      $error("FAIL %s invariant observed=%b expected=1 outputs=%b", tag, ok, o);
    end
  endtask

  task automatic cyc(input logic s, input logic [2:0] o, input logic st, input logic r);
    start = s;
    op    = o;
    stall = st;
    rst   = r;
    @(posedge clk);
    model_edge(0, SC0);
    model_edge(1, SC1);
    @(negedge clk);
    check("sc2_outputs", observe(0), cur[0]);
    check("sc1_outputs", observe(1), cur[1]);
    check_inv("sc2", observe(0));
    check_inv("sc1", observe(1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int busy_cnt;
    cur[0] = IDLE_V;
    cur[1] = IDLE_V;

    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    check("reset_state", observe(0), IDLE_V);
    idle(1);

    // INC: SC=1 shows I step then done
    cyc(1'b1, 3'd3, 1'b0, 1'b0);
    check("inc_first", observe(1), 7'b0101_100);
    idle(1);
    check("inc_done", observe(1), 7'b1111_010);
    idle(3);

    // PREDEC on SC=2 is busy for exactly four cycles
    cyc(1'b1, 3'd6, 1'b0, 1'b0);
    busy_cnt = int'(bus0.busy);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      busy_cnt += int'(bus0.busy);
    end
    vectors++;
    assert (busy_cnt === 4) else begin
      miscompares++;
      $error("FAIL predec_busy observed=%0d expected=4", busy_cnt);
    end

    // POSTINC with a three-cycle stall during the A step
    cyc(1'b1, 3'd5, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 3'd0, 1'b1, 1'b0);
    check("postinc_stalled_a", observe(0), 7'b1011_100);
    idle(7);

    // Start accepted in DONE, and a start during busy is ignored
    cyc(1'b1, 3'd3, 1'b0, 1'b0);
    idle(2);
    check("done_before_b2b", observe(0), 7'b1111_010);
    cyc(1'b1, 3'd2, 1'b0, 1'b0);
    check("b2b_mov", observe(0), 7'b0111_100);
    cyc(1'b1, 3'd4, 1'b0, 1'b0);
    idle(6);

    // Reserved and NOP ops
    cyc(1'b1, 3'd7, 1'b0, 1'b0);
    check("reserved_err", observe(0), 7'b1111_011);
    idle(2);
    cyc(1'b1, 3'd0, 1'b0, 1'b0);
    check("nop_done", observe(0), 7'b1111_010);
    idle(2);

    // Reset in the middle of PREDEC STEP1, then a fresh start
    cyc(1'b1, 3'd6, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    check("mid_reset", observe(0), IDLE_V);
    cyc(1'b1, 3'd1, 1'b0, 1'b0);
    check("after_reset_addr", observe(0), 7'b1011_100);
    idle(4);

    for (int n = 0; n < 800; n++) begin
      cyc(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_internal_seq.md
Name: alu_internal_seq

Overview:
- Micro-step sequencer directly upstream of the ALU Ctrl2 decoder.
- Turns a one-cycle internal-operation request into a timed sequence of active-low strobes: INTERNAL_MOV, ADDRESS_MODE, INTERNAL_INC_DEC and INTERNAL_DEC.
- The decoder consumes these strobes to override Ctrl2 during address calculation and register MOV/INC/DEC.
- Supports compound post-increment and pre-decrement addressing sequences.

Parameters:
- STEP_CYCLES, 1, clocks each micro-step is held active (1..15).
- CNT_W, 4, width of the step-hold counter; must satisfy STEP_CYCLES < 2**CNT_W.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only while busy=0.
- op  input  3  operation code, sampled with start.
- stall  input  1  freezes sequencer state, counter and outputs while high.
- INTERNAL_MOV  output  1  active-low internal MOV strobe.
- ADDRESS_MODE  output  1  active-low address-calculation mode.
- INTERNAL_INC_DEC  output  1  active-low increment/decrement strobe.
- INTERNAL_DEC  output  1  active-low; 0 selects decrement when INTERNAL_INC_DEC=0.
- busy  output  1  high while micro-steps are in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse on a reserved op.

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high.
- Reset state: state=IDLE, counter=0. Outputs are INTERNAL_MOV=1, ADDRESS_MODE=1, INTERNAL_INC_DEC=1, INTERNAL_DEC=1, busy=0, done=0, err=0.
- Op codes:
  - 0 NOP: no steps.
  - 1 ADDR: one A step.
  - 2 MOV: one M step.
  - 3 INC: one I step.
  - 4 DEC: one D step.
  - 5 POSTINC: A then I.
  - 6 PREDEC: D then A.
  - 7 reserved.
- Step encodings, all outputs registered:
  - A: ADDRESS_MODE=0, others 1.
  - M: INTERNAL_MOV=0, others 1.
  - I: INTERNAL_MOV=0, INTERNAL_INC_DEC=0, INTERNAL_DEC=1, ADDRESS_MODE=1.
  - D: INTERNAL_MOV=0, INTERNAL_INC_DEC=0, INTERNAL_DEC=0, ADDRESS_MODE=1.
  - Idle/done: all four outputs = 1.
- Invariants:
  - INTERNAL_INC_DEC=0 implies INTERNAL_MOV=0.
  - INTERNAL_DEC=0 implies INTERNAL_INC_DEC=0.
  - ADDRESS_MODE=0 never coincides with INTERNAL_MOV=0.
- States: IDLE, STEP1, STEP2, DONE.
- IDLE:
  - start=1 with op 1..6 -> STEP1 on the next edge. The first step's strobes and busy=1 appear in the cycle after start.
  - start=1 with op 0 -> DONE; no strobes.
  - start=1 with op 7 -> DONE with err=1 in the same cycle as done.
- STEP1 and STEP2:
  - The counter counts 0..STEP_CYCLES-1, then advances.
  - Single-step ops go STEP1 -> DONE.
  - Compound ops go STEP1 -> STEP2 -> DONE.
  - No gap cycle between STEP1 and STEP2; the strobes change on the same edge.
- DONE: done=1, busy=0, strobes all 1, for exactly one cycle, then IDLE.
  - start is accepted in DONE; it behaves as if in IDLE, giving back-to-back ops with one done cycle between sequences.
- start while busy=1: ignored; op is not latched.
- op is latched at acceptance. Later changes to op have no effect.
- stall=1:
  - In STEP1/STEP2: hold state, counter and strobes unchanged.
  - In IDLE: start is still accepted.
  - In DONE: done is held high until stall drops.
- Sequence length: total busy cycles = steps x STEP_CYCLES + stall cycles.
- rst asserted mid-sequence: on the next edge return to reset state. No done pulse and no partial completion.

Test Plan:
- Reset then op=3 start, STEP_CYCLES=1 -> the next cycle shows MOV=0, INC_DEC=0, DEC=1, ADDR=1, busy=1. The cycle after shows done=1 and all strobes=1.
- op=6 (PREDEC), STEP_CYCLES=2 -> 2 cycles of (0,1,0,0), then 2 cycles of ADDRESS_MODE=0 only, then done. busy is high for exactly 4 cycles.
- op=5 with stall=1 for 3 cycles during the A step -> ADDRESS_MODE stays 0 for 1+3 cycles, then the I step, then done. No invariant violation.
- start on the DONE cycle with op=2 -> M step follows immediately. A second start pulsed while busy is ignored, giving exactly one done per accepted start.
- op=7 -> done=1 and err=1 in the same cycle; op=0 -> done only, and no strobe ever goes to 0.
- rst=1 in the middle of a PREDEC STEP1 -> the next cycle has all strobes=1, busy=0, done=0. A new start is accepted afterwards.
